// File: rtl/baud_rate_controller.sv
// baud_rate_controller: shared UART timebase producing oversample and bit ticks,
// with a valid/ready divisor update that is only applied on a bit boundary.
module baud_rate_controller #(
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 326,
   parameter int OVERSAMPLE  = 16
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 cfg_valid,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic                 cfg_ready,
   output logic                 cfg_err,
   output logic                 tick_os,
   output logic                 tick_bit,
   output logic [DIV_WIDTH-1:0] div_active,
   output logic                 running
);
   localparam int BW = $clog2(OVERSAMPLE);
   typedef enum logic [1:0] {IDLE, RUN, RELOAD} state_t;
   state_t               r_state, w_state;
   logic [DIV_WIDTH-1:0] r_os_cnt, w_os_cnt;
   logic [DIV_WIDTH-1:0] r_div, w_div;
   logic [DIV_WIDTH-1:0] r_pending, w_pending;
   logic [BW-1:0]        r_bit_cnt, w_bit_cnt;
   logic                 r_ready, w_ready;
   logic                 r_err, w_err;
   logic                 r_tick_os, w_tick_os;
   logic                 r_tick_bit, w_tick_bit;
   logic                 w_accept, w_good, w_wrap, w_bwrap;

   assign w_accept   = cfg_valid & r_ready;
   assign w_good     = cfg_div >= DIV_WIDTH'(2);
   assign w_wrap     = r_os_cnt == r_div - DIV_WIDTH'(1);
   assign w_bwrap    = r_bit_cnt == BW'(OVERSAMPLE - 1);
   assign cfg_ready  = r_ready;
   assign cfg_err    = r_err;
   assign tick_os    = r_tick_os;
   assign tick_bit   = r_tick_bit;
   assign div_active = r_div;
   assign running    = r_state != IDLE;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_os_cnt   <= '0;
         r_bit_cnt  <= '0;
         r_div      <= DIV_WIDTH'(DEFAULT_DIV);
         r_pending  <= DIV_WIDTH'(DEFAULT_DIV);
         r_ready    <= 1'b1;
         r_err      <= 1'b0;
         r_tick_os  <= 1'b0;
         r_tick_bit <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_os_cnt   <= w_os_cnt;
         r_bit_cnt  <= w_bit_cnt;
         r_div      <= w_div;
         r_pending  <= w_pending;
         r_ready    <= w_ready;
         r_err      <= w_err;
         r_tick_os  <= w_tick_os;
         r_tick_bit <= w_tick_bit;
      end
   end

   // Counters default to zero so every path into IDLE or a reload restarts phase.
   always_comb begin
      w_state    = r_state;
      w_os_cnt   = '0;
      w_bit_cnt  = '0;
      w_div      = r_div;
      w_pending  = r_pending;
      w_ready    = r_ready;
      w_err      = w_accept & ~w_good;
      w_tick_os  = 1'b0;
      w_tick_bit = 1'b0;
      if (r_state == IDLE) begin
         w_ready = 1'b1;
         if (w_accept && w_good) w_div = cfg_div;
         if (enable) w_state = RUN;
      end else if (!enable) begin
         w_state = IDLE;
         w_ready = 1'b1;
         if (r_state == RELOAD) w_div = r_pending;
         else if (w_accept && w_good) w_div = cfg_div;
      end else if (r_state == RELOAD && r_tick_bit) begin
         w_state = RUN;
         w_div   = r_pending;
         w_ready = 1'b1;
      end else begin
         w_os_cnt   = w_wrap ? '0 : r_os_cnt + DIV_WIDTH'(1);
         w_bit_cnt  = w_wrap ? (w_bwrap ? '0 : r_bit_cnt + BW'(1)) : r_bit_cnt;
         w_tick_os  = w_wrap;
         w_tick_bit = w_wrap & w_bwrap;
         if (r_state == RUN && w_accept && w_good) begin
            w_pending = cfg_div;
            w_ready   = 1'b0;
            w_state   = RELOAD;
         end
      end
   end
endmodule

// File: tb/tb_baud_rate_controller.sv
// tb_baud_rate_controller: table-driven cycle checks with a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_baud_rate_controller;
   typedef struct packed {
      logic        tos;
      logic        tbit;
      logic        rdy;
      logic        err;
      logic [15:0] div;
      logic        run;
   } out_t;
   typedef struct {
      logic        en;
      logic        v;
      logic [15:0] d;
      out_t        e;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [15:0] cfg_div = '0;
   logic        cfg_ready, cfg_err, tick_os, tick_bit, running;
   logic [15:0] div_active;
   vec_t        vecs[$];
   out_t        sb[$];
   int          n_tests = 0;
   int          n_fail = 0;

   baud_rate_controller #(.DIV_WIDTH(16), .DEFAULT_DIV(4), .OVERSAMPLE(4)) dut (
      .clk_in(clk_in), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
      .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .tick_os(tick_os),
      .tick_bit(tick_bit), .div_active(div_active), .running(running)
   );

   always #5 clk_in = ~clk_in;

   task automatic add(input bit en, input bit v, input int d, input bit tos, input bit tbit,
                      input bit rdy, input bit err, input int dv, input bit run);
      vec_t x;
      x.en = en;
      x.v  = v;
      x.d  = 16'(d);
      x.e  = '{tos, tbit, rdy, err, 16'(dv), run};
      vecs.push_back(x);
   endtask

   task automatic check(input string name, input int idx);
      out_t a, w;
      w = sb.pop_front();
      a = '{tick_os, tick_bit, cfg_ready, cfg_err, div_active, running};
      n_tests++;
      if (a !== w) begin
         n_fail++;
         $display("FAIL %s[%0d]: got tos=%b bit=%b rdy=%b err=%b div=%0d run=%b, want tos=%b bit=%b rdy=%b err=%b div=%0d run=%b",
                  name, idx, a.tos, a.tbit, a.rdy, a.err, a.div, a.run,
                  w.tos, w.tbit, w.rdy, w.err, w.div, w.run);
      end
   endtask

   task automatic step(input vec_t x, input string name, input int idx);
      sb.push_back(x.e);
      enable    = x.en;
      cfg_valid = x.v;
      cfg_div   = x.d;
      @(posedge clk_in);
      #1;
      check(name, idx);
   endtask

   initial begin
      vec_t h;
      // run at default divisor 4: tick_os every 4, tick_bit every 16
      add(1, 0, 0, 0, 0, 1, 0, 4, 1);
      for (int k = 1; k <= 32; k++) add(1, 0, 0, k % 4 == 0, k % 16 == 0, 1, 0, 4, 1);
      add(0, 0, 0, 0, 0, 1, 0, 4, 0);
      // divisor 2 loaded in IDLE
      add(0, 1, 2, 0, 0, 1, 0, 2, 0);
      add(1, 0, 0, 0, 0, 1, 0, 2, 1);
      for (int k = 1; k <= 16; k++) add(1, 0, 0, k % 2 == 0, k % 8 == 0, 1, 0, 2, 1);
      add(0, 0, 0, 0, 0, 1, 0, 2, 0);
      add(0, 1, 4, 0, 0, 1, 0, 4, 0);
      // mid-bit reload to 6; a second offer while not ready is ignored
      add(1, 0, 0, 0, 0, 1, 0, 4, 1);
      for (int k = 1; k <= 8; k++) add(1, 0, 0, k % 4 == 0, 0, 1, 0, 4, 1);
      add(1, 1, 6, 0, 0, 0, 0, 4, 1);
      for (int k = 10; k <= 16; k++) add(1, k == 11, 9, k % 4 == 0, k == 16, 0, 0, 4, 1);
      add(1, 0, 0, 0, 0, 1, 0, 6, 1);
      for (int k = 1; k <= 24; k++) add(1, 0, 0, k % 6 == 0, k == 24, 1, 0, 6, 1);
      add(0, 0, 0, 0, 0, 1, 0, 6, 0);
      // rejected divisors in IDLE and RUN
      add(0, 1, 4, 0, 0, 1, 0, 4, 0);
      add(0, 1, 0, 0, 0, 1, 1, 4, 0);
      add(1, 0, 0, 0, 0, 1, 0, 4, 1);
      for (int k = 1; k <= 16; k++)
         add(1, k == 2 || k == 6, k == 2 ? 1 : 0, k % 4 == 0, k == 16, 1, k == 2 || k == 6, 4, 1);
      add(0, 0, 0, 0, 0, 1, 0, 4, 0);
      // enable dropped during RELOAD applies the pending divisor
      add(1, 0, 0, 0, 0, 1, 0, 4, 1);
      for (int k = 1; k <= 8; k++) add(1, k == 5, 6, k % 4 == 0, 0, k < 5, 0, 4, 1);
      for (int k = 9; k <= 12; k++) add(0, 0, 0, 0, 0, 1, 0, 6, 0);
      add(1, 0, 0, 0, 0, 1, 0, 6, 1);
      for (int k = 1; k <= 12; k++) add(1, 0, 0, k % 6 == 0, 0, 1, 0, 6, 1);

      #12;
      sb.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0});
      check("reset", 0);
      reset = 1'b1;
      foreach (vecs[i]) step(vecs[i], "vec", i);

      // async reset between edges while tick_os is high
      #2 reset = 1'b0;
      #1;
      sb.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0});
      check("rst_async", 0);
      @(posedge clk_in);
      #1;
      sb.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0});
      check("rst_hold", 0);
      #3 reset = 1'b1;
      h.en = 1'b1;
      h.v  = 1'b0;
      h.d  = '0;
      h.e  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1};
      step(h, "post_rst", 0);
      for (int k = 1; k <= 16; k++) begin
         h.e = '{k % 4 == 0, k == 16, 1'b1, 1'b0, 16'd4, 1'b1};
         step(h, "post_rst", k);
      end
      h.en = 1'b0;
      h.e  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0};
      step(h, "post_rst_off", 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/baud_rate_controller.md
Name: baud_rate_controller

Overview:
Programmable baud-tick controller for the UART path. It sequences the divider so that TX and RX share one timebase. It produces a single-cycle oversample tick and a bit tick. It also accepts new divisor values through a valid/ready handshake and applies each one only on a bit boundary, so no character in flight is corrupted.

Parameters:
DIV_WIDTH, 16, width of divisor and oversample counter
DEFAULT_DIV, 326, divisor loaded at reset (50 MHz / (9600*16), rounded)
OVERSAMPLE, 16, tick_os pulses per tick_bit (>=2)

Ports:
clk_in  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = run tick generation, 0 = idle
cfg_valid  input  1  new divisor offered
cfg_div  input  DIV_WIDTH  offered divisor, cycles per tick_os
cfg_ready  output  1  controller can accept a divisor
cfg_err  output  1  one-cycle pulse: offered divisor rejected
tick_os  output  1  one-cycle oversample tick
tick_bit  output  1  one-cycle bit tick, coincident with every OVERSAMPLE-th tick_os
div_active  output  DIV_WIDTH  divisor currently in use
running  output  1  1 while in RUN or RELOAD

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; os_cnt=0; bit_cnt=0; pending=DEFAULT_DIV.
  - div_active=DEFAULT_DIV; cfg_ready=1; cfg_err=0; tick_os=0; tick_bit=0; running=0.
  - Takes effect immediately, including mid-operation; no tick is emitted during or after reset assertion.
- Counter widths:
  - os_cnt is DIV_WIDTH bits; bit_cnt is clog2(OVERSAMPLE) bits.
  - Compares are against div_active-1 and OVERSAMPLE-1; no overflow is possible.
- State IDLE:
  - Counters held at 0, no ticks, running=0.
  - An accepted cfg (cfg_valid&cfg_ready, cfg_div>=2) sets div_active=cfg_div on the next edge.
  - enable=1 sampled -> RUN on the next edge; os_cnt starts at 0.
  - Simultaneous cfg and enable: the new divisor is used from the first RUN cycle.
- State RUN:
  - os_cnt increments each cycle and wraps to 0 after div_active-1.
  - tick_os is registered: high for exactly one cycle each time os_cnt wraps. First tick_os occurs div_active cycles after the RUN entry edge; thereafter its period is exactly div_active.
  - bit_cnt increments on each tick_os and wraps after OVERSAMPLE-1.
  - tick_bit=1 in the same cycle as the tick_os that wraps bit_cnt.
  - Accepted valid cfg: pending=cfg_div, cfg_ready=0 on the next edge -> RELOAD.
- State RELOAD:
  - Ticks continue at the old divisor; cfg_ready=0.
  - On the cycle tick_bit is asserted, the following happen together and ticks then continue at the new period:
    - div_active=pending on the next edge;
    - os_cnt=0 and bit_cnt=0;
    - cfg_ready=1;
    - state returns to RUN.
- Rejection:
  - cfg_div<2 with cfg_valid&cfg_ready -> handshake completes, cfg_err=1 for one cycle.
  - div_active, pending and state are unchanged; rejection is possible in IDLE or RUN.
- enable=0 sampled in RUN or RELOAD:
  - Next edge -> IDLE; counters cleared; no tick on that edge.
  - If in RELOAD, div_active=pending and cfg_ready=1 on the same edge.
- Re-enable always restarts phase from 0; no partial-period carryover.
- cfg_valid while cfg_ready=0 is ignored (not latched); the requester holds it until cfg_ready=1.

Test Plan:
1. Params DEFAULT_DIV=4, OVERSAMPLE=4; release reset, enable=1 -> first tick_os 4 cycles after RUN entry, then every 4 cycles; tick_bit every 16 cycles, coincident with the 4th tick_os; running=1.
2. IDLE, cfg_valid=1, cfg_div=2 for one cycle -> div_active=2 on the next cycle, cfg_ready stays 1; after enable, tick_os every 2 cycles, tick_bit every 8.
3. RUN at div 4, cfg_div=6 offered mid-bit (after 2nd tick_os) -> cfg_ready=0 next cycle, remaining ticks spaced 4 until tick_bit; then div_active=6, cfg_ready=1, next tick_os 6 cycles later.
4. cfg_div=1 (also 0) offered in RUN -> cfg_err one-cycle pulse, div_active remains 4, tick spacing unchanged, cfg_ready stays 1.
5. RELOAD pending=6, enable dropped before tick_bit -> IDLE next cycle, running=0, no further ticks, div_active=6, cfg_ready=1; re-enable gives first tick_os after 6 cycles.
6. reset pulled low mid-RUN, between clock edges -> tick_os/tick_bit/running=0 and div_active=DEFAULT_DIV immediately; after release with enable=1, timing identical to scenario 1.
